// File: rtl/ulpb_tx_arbiter_pkg.sv
// Shared widths, retry limit and FSM state encoding for the ulpb transmit arbiter.
// No logic here and no timing or backpressure of its own.
package ulpb_tx_arbiter_pkg;

  localparam int ULPB_ADDR_WIDTH = 8;
  localparam int ULPB_DATA_WIDTH = 32;
  localparam int ULPB_MAX_RETRY  = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_ACKWAIT     = 3'd2,
    ST_HOLD        = 3'd3,
    ST_RESPWAIT    = 3'd4,
    ST_NODE_RACK   = 3'd5,
    ST_CLIENT_RESP = 3'd6
  } arb_state_t;

endpackage

// File: rtl/ulpb_rr_pick.sv
// Combinational picker: the priority class wins, then the first requester at or after rr_ptr.
// Zero latency; it never stalls anything and only reports the winner.
module ulpb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] prio,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;

  always_comb begin
    cand = (|(req & prio)) ? (req & prio) : req;
  end

  assign any = |cand;

  // Walk from the far end back towards rr_ptr so the nearest candidate is written last.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (cand[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// Shares one node TX port among NUM_REQ clients: REQ_ACK/TX_* one cycle after a sampled request, TX_REQ one later.
// Backpressure is the 4-phase handshake on both sides; a multi-word message owns the port until its outcome is consumed.
module ulpb_tx_arbiter
  import ulpb_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
  parameter int MAX_RETRY  = ULPB_MAX_RETRY
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  output logic [NUM_REQ-1:0]             REQ_ACK,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
  input  logic [NUM_REQ-1:0]             REQ_PEND,
  input  logic [NUM_REQ-1:0]             REQ_PRIORITY,
  output logic [NUM_REQ-1:0]             RESP_SUCC,
  output logic [NUM_REQ-1:0]             RESP_FAIL,
  input  logic [NUM_REQ-1:0]             RESP_ACK,
  output logic [ADDR_WIDTH-1:0]          TX_ADDR,
  output logic [DATA_WIDTH-1:0]          TX_DATA,
  output logic                           TX_PEND,
  output logic                           PRIORITY,
  output logic                           TX_REQ,
  input  logic                           TX_ACK,
  input  logic                           TX_SUCC,
  input  logic                           TX_FAIL,
  output logic                           TX_RESP_ACK
);

  localparam int IDXW = $clog2(NUM_REQ);

  arb_state_t state_q, state_d;

  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic [2:0]            retry_q, retry_d;
  logic                  multi_q, multi_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pend_q, pend_d;
  logic                  prio_q, prio_d;
  logic                  tx_req_q, tx_req_d;
  logic                  rack_q, rack_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]    resp_succ_q, resp_succ_d;
  logic [NUM_REQ-1:0]    resp_fail_q, resp_fail_d;

  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i] = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A client whose last word is still acknowledged is not a new request yet.
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_any;

  ulpb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req    (REQ_VALID & ~req_ack_q),
    .prio   (REQ_PRIORITY),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  logic            load_word;
  logic [IDXW-1:0] load_idx;
  logic            outcome_in;

  assign outcome_in = TX_SUCC | TX_FAIL;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    retry_d     = retry_q;
    multi_d     = multi_q;
    fail_d      = fail_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = pend_q;
    prio_d      = prio_q;
    tx_req_d    = tx_req_q;
    rack_d      = rack_q;
    req_ack_d   = req_ack_q & REQ_VALID;
    resp_succ_d = resp_succ_q;
    resp_fail_d = resp_fail_q;
    load_word   = 1'b0;
    load_idx    = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          load_word = 1'b1;
          load_idx  = pick_idx;
          owner_d   = pick_idx;
          req_ack_d = req_ack_d | pick_grant;
          retry_d   = '0;
          multi_d   = REQ_PEND[pick_idx];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tx_req_q && TX_ACK) begin
          tx_req_d = 1'b0;
          state_d  = ST_ACKWAIT;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      ST_ACKWAIT: begin
        if (!TX_ACK) state_d = pend_q ? ST_HOLD : ST_RESPWAIT;
      end
      ST_HOLD: begin
        if (outcome_in) begin
          fail_d  = TX_FAIL;
          rack_d  = 1'b1;
          state_d = ST_NODE_RACK;
        end else if (REQ_VALID[owner_q] && !req_ack_q[owner_q]) begin
          load_word          = 1'b1;
          req_ack_d[owner_q] = 1'b1;
          state_d            = ST_ISSUE;
        end
      end
      ST_RESPWAIT: begin
        if (outcome_in) begin
          fail_d  = TX_FAIL;
          rack_d  = 1'b1;
          state_d = ST_NODE_RACK;
        end
      end
      ST_NODE_RACK: begin
        if (!outcome_in) begin
          rack_d = 1'b0;
          if (fail_q && !multi_q && (retry_q < 3'(MAX_RETRY))) begin
            retry_d = retry_q + 3'd1;
            state_d = ST_ISSUE;
          end else begin
            resp_succ_d[owner_q] = !fail_q;
            resp_fail_d[owner_q] = fail_q;
            rr_ptr_d = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + IDXW'(1);
            state_d  = ST_CLIENT_RESP;
          end
        end
      end
      ST_CLIENT_RESP: begin
        if (resp_succ_q[owner_q] || resp_fail_q[owner_q]) begin
          if (RESP_ACK[owner_q]) begin
            resp_succ_d[owner_q] = 1'b0;
            resp_fail_d[owner_q] = 1'b0;
          end
        end else if (!RESP_ACK[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_word) begin
      addr_d = req_addr[load_idx];
      data_d = req_data[load_idx];
      pend_d = REQ_PEND[load_idx];
      prio_d = REQ_PRIORITY[load_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      retry_q     <= '0;
      multi_q     <= 1'b0;
      fail_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      prio_q      <= 1'b0;
      tx_req_q    <= 1'b0;
      rack_q      <= 1'b0;
      req_ack_q   <= '0;
      resp_succ_q <= '0;
      resp_fail_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      retry_q     <= retry_d;
      multi_q     <= multi_d;
      fail_q      <= fail_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      prio_q      <= prio_d;
      tx_req_q    <= tx_req_d;
      rack_q      <= rack_d;
      req_ack_q   <= req_ack_d;
      resp_succ_q <= resp_succ_d;
      resp_fail_q <= resp_fail_d;
    end
  end

  assign REQ_ACK     = req_ack_q;
  assign RESP_SUCC   = resp_succ_q;
  assign RESP_FAIL   = resp_fail_q;
  assign TX_ADDR     = addr_q;
  assign TX_DATA     = data_q;
  assign TX_PEND     = pend_q;
  assign PRIORITY    = prio_q;
  assign TX_REQ      = tx_req_q;
  assign TX_RESP_ACK = rack_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Directed bench for ulpb_tx_arbiter: four clients, a hand-driven node, fixed expected grant orders and outcomes.
module tb_ulpb_tx_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  REQ_VALID, REQ_ACK, REQ_PEND, REQ_PRIORITY;
  logic [31:0] REQ_ADDR;
  logic [127:0] REQ_DATA;
  logic [3:0]  RESP_SUCC, RESP_FAIL, RESP_ACK;
  logic [7:0]  TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_PEND, PRIORITY, TX_REQ, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ulpb_tx_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .REQ_VALID(REQ_VALID), .REQ_ACK(REQ_ACK), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_PEND(REQ_PEND), .REQ_PRIORITY(REQ_PRIORITY),
    .RESP_SUCC(RESP_SUCC), .RESP_FAIL(RESP_FAIL), .RESP_ACK(RESP_ACK),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .PRIORITY(PRIORITY),
    .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel, input int idx);
    case (sel)
      0:       return TX_REQ;
      1:       return TX_RESP_ACK;
      2:       return RESP_SUCC[idx] | RESP_FAIL[idx];
      default: return |REQ_ACK;
    endcase
  endfunction

  // Bounded wait; an expired budget shows up as a failed comparison.
  task automatic wait_for(input string tag, input int sel, input int idx, input logic val);
    int n;
    n = 0;
    while (probe(sel, idx) !== val && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 64'(probe(sel, idx)), 64'(val));
  endtask

  task automatic set_word(input int i, input logic [7:0] a, input logic [31:0] d,
                          input logic p, input logic pr);
    REQ_ADDR[i*8 +: 8]   = a;
    REQ_DATA[i*32 +: 32] = d;
    REQ_PEND[i]          = p;
    REQ_PRIORITY[i]      = pr;
  endtask

  task automatic grab(input string tag, input int who);
    logic [3:0] oh;
    oh      = '0;
    oh[who] = 1'b1;
    wait_for({tag, "_ack"}, 3, 0, 1'b1);
    chk({tag, "_vec"}, 64'(REQ_ACK), 64'(oh));
    REQ_VALID = REQ_VALID & ~REQ_ACK;
  endtask

  // outcome: -1 none (more words follow), 0 success, 1 fail, 2 success and fail together
  task automatic node_word(input string tag, input int outcome, input logic [7:0] ea,
                           input logic [31:0] ed, input logic ep, input logic epr);
    wait_for({tag, "_txreq"}, 0, 0, 1'b1);
    chk({tag, "_addr"}, 64'(TX_ADDR), 64'(ea));
    chk({tag, "_data"}, 64'(TX_DATA), 64'(ed));
    chk({tag, "_pend"}, 64'(TX_PEND), 64'(ep));
    chk({tag, "_prio"}, 64'(PRIORITY), 64'(epr));
    TX_ACK = 1'b1;
    wait_for({tag, "_txreq_fall"}, 0, 0, 1'b0);
    TX_ACK = 1'b0;
    if (outcome >= 0) begin
      TX_SUCC = (outcome == 0 || outcome == 2);
      TX_FAIL = (outcome != 0);
      wait_for({tag, "_rack_rise"}, 1, 0, 1'b1);
      TX_SUCC = 1'b0;
      TX_FAIL = 1'b0;
      wait_for({tag, "_rack_fall"}, 1, 0, 1'b0);
    end
  endtask

  task automatic finish_msg(input string tag, input int who, input logic fail);
    logic [3:0] oh;
    oh      = '0;
    oh[who] = 1'b1;
    wait_for({tag, "_resp"}, 2, who, 1'b1);
    chk({tag, "_succ"}, 64'(RESP_SUCC), fail ? 64'(0) : 64'(oh));
    chk({tag, "_fail"}, 64'(RESP_FAIL), fail ? 64'(oh) : 64'(0));
    RESP_ACK[who] = 1'b1;
    wait_for({tag, "_resp_clr"}, 2, who, 1'b0);
    RESP_ACK[who] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  exp_who;
    logic seen;

    resetn = 1'b0;
    REQ_VALID = '0; REQ_PEND = '0; REQ_PRIORITY = '0; REQ_ADDR = '0; REQ_DATA = '0;
    RESP_ACK = '0; TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    tick();
    tick();
    chk("rst_req_ack", 64'(REQ_ACK), 64'(0));
    chk("rst_tx_req", 64'(TX_REQ), 64'(0));
    chk("rst_tx_addr", 64'(TX_ADDR), 64'(0));
    chk("rst_tx_data", 64'(TX_DATA), 64'(0));
    chk("rst_resp", 64'({RESP_SUCC, RESP_FAIL}), 64'(0));
    chk("rst_misc", 64'({TX_PEND, PRIORITY, TX_RESP_ACK}), 64'(0));
    resetn = 1'b1;
    tick();

    // Single word from client 1 with exact cycle-level latencies.
    set_word(1, 8'hef, 32'hdeadbeef, 1'b0, 1'b0);
    REQ_VALID = 4'b0010;
    tick();
    chk("t1_req_ack", 64'(REQ_ACK), 64'(4'b0010));
    chk("t1_tx_addr", 64'(TX_ADDR), 64'(8'hef));
    chk("t1_tx_data", 64'(TX_DATA), 64'(32'hdeadbeef));
    chk("t1_tx_req_lat", 64'(TX_REQ), 64'(0));
    tick();
    chk("t1_tx_req", 64'(TX_REQ), 64'(1));
    REQ_VALID = '0;
    TX_ACK = 1'b1;
    tick();
    chk("t1_tx_req_fall", 64'(TX_REQ), 64'(0));
    chk("t1_req_ack_fall", 64'(REQ_ACK), 64'(0));
    TX_ACK = 1'b0;
    tick();
    TX_SUCC = 1'b1;
    tick();
    chk("t1_rack_rise", 64'(TX_RESP_ACK), 64'(1));
    TX_SUCC = 1'b0;
    tick();
    chk("t1_rack_fall", 64'(TX_RESP_ACK), 64'(0));
    chk("t1_resp_succ", 64'(RESP_SUCC), 64'(4'b0010));
    chk("t1_resp_fail", 64'(RESP_FAIL), 64'(0));
    RESP_ACK[1] = 1'b1;
    tick();
    chk("t1_resp_clr", 64'(RESP_SUCC), 64'(0));
    RESP_ACK[1] = 1'b0;
    tick();

    // Round robin from rr_ptr=2 among clients 0,2,3: order 2,3,0.
    for (int i = 0; i < 4; i++)
      if (i != 1) set_word(i, 8'h10 + 8'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
    REQ_VALID = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      exp_who = (k == 0) ? 2 : (k == 1) ? 3 : 0;
      grab("t2_grant", exp_who);
      node_word("t2_word", 0, 8'h10 + 8'(exp_who), 32'h1000_0000 + 32'(exp_who), 1'b0, 1'b0);
      finish_msg("t2", exp_who, 1'b0);
    end

    // rr_ptr=1: client 3 with priority beats 0 and 1; then 0, 1 by round robin.
    set_word(0, 8'h30, 32'h3000_0000, 1'b0, 1'b0);
    set_word(1, 8'h31, 32'h3000_0001, 1'b0, 1'b0);
    set_word(3, 8'h33, 32'h3000_0003, 1'b0, 1'b1);
    REQ_VALID = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      exp_who = (k == 0) ? 3 : (k == 1) ? 0 : 1;
      grab("t3_grant", exp_who);
      node_word("t3_word", 0, 8'h30 + 8'(exp_who), 32'h3000_0000 + 32'(exp_who), 1'b0,
                exp_who == 3);
      finish_msg("t3", exp_who, 1'b0);
    end
    REQ_PRIORITY = '0;

    // rr_ptr=2: three-word message from client 0 while client 1 waits.
    set_word(0, 8'h40, 32'h0000_00a0, 1'b1, 1'b0);
    set_word(1, 8'h41, 32'h0000_00b1, 1'b0, 1'b0);
    REQ_VALID = 4'b0011;
    grab("t4_w0_grant", 0);
    node_word("t4_w0", -1, 8'h40, 32'h0000_00a0, 1'b1, 1'b0);
    set_word(0, 8'h44, 32'h0000_00a1, 1'b1, 1'b0);
    REQ_VALID[0] = 1'b1;
    grab("t4_w1_grant", 0);
    node_word("t4_w1", -1, 8'h44, 32'h0000_00a1, 1'b1, 1'b0);
    set_word(0, 8'h48, 32'h0000_00a2, 1'b0, 1'b0);
    REQ_VALID[0] = 1'b1;
    grab("t4_w2_grant", 0);
    node_word("t4_w2", 0, 8'h48, 32'h0000_00a2, 1'b0, 1'b0);
    finish_msg("t4_c0", 0, 1'b0);
    grab("t4_c1_grant", 1);
    node_word("t4_c1", 0, 8'h41, 32'h0000_00b1, 1'b0, 1'b0);
    finish_msg("t4_c1", 1, 1'b0);

    // rr_ptr=2: single word failing three times (last with SUCC and FAIL together).
    set_word(2, 8'h50, 32'h5555_0002, 1'b0, 1'b0);
    REQ_VALID = 4'b0100;
    grab("t5_grant", 2);
    node_word("t5_try0", 1, 8'h50, 32'h5555_0002, 1'b0, 1'b0);
    chk("t5_no_resp0", 64'({RESP_SUCC, RESP_FAIL}), 64'(0));
    node_word("t5_try1", 1, 8'h50, 32'h5555_0002, 1'b0, 1'b0);
    chk("t5_no_resp1", 64'({RESP_SUCC, RESP_FAIL}), 64'(0));
    node_word("t5_try2", 2, 8'h50, 32'h5555_0002, 1'b0, 1'b0);
    finish_msg("t5", 2, 1'b1);

    // Reset while TX_REQ is up: outputs clear at once, no outcome afterwards.
    set_word(3, 8'h60, 32'h6666_0003, 1'b0, 1'b0);
    REQ_VALID = 4'b1000;
    grab("t6_grant", 3);
    wait_for("t6_txreq", 0, 0, 1'b1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_tx_req", 64'(TX_REQ), 64'(0));
    chk("t6_rst_req_ack", 64'(REQ_ACK), 64'(0));
    chk("t6_rst_tx_addr", 64'(TX_ADDR), 64'(0));
    chk("t6_rst_tx_data", 64'(TX_DATA), 64'(0));
    REQ_VALID = '0;
    tick();
    tick();
    resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | TX_REQ | TX_RESP_ACK | (|RESP_SUCC) | (|RESP_FAIL) | (|REQ_ACK);
    end
    chk("t6_quiet", 64'(seen), 64'(0));

    // rr_ptr is back at 0 after reset: client 1 before client 3.
    set_word(1, 8'h71, 32'h7777_0001, 1'b0, 1'b0);
    set_word(3, 8'h73, 32'h7777_0003, 1'b0, 1'b0);
    REQ_VALID = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      exp_who = (k == 0) ? 1 : 3;
      grab("t7_grant", exp_who);
      node_word("t7_word", 0, 8'h70 + 8'(exp_who), 32'h7777_0000 + 32'(exp_who), 1'b0, 1'b0);
      finish_msg("t7", exp_who, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ulpb_tx_arbiter.md
# ulpb_tx_arbiter

Shares one ulpb_node32 transmit port among NUM_REQ local requesters, such as a register file, a DMA engine and a sensor FIFO, inside a layer wrapper. It arbitrates with priority then round-robin and sequences the node's 4-phase TX_REQ/TX_ACK handshake. It holds the grant across multi-word (TX_PEND) messages, retries failed single-word messages, and routes TX_SUCC/TX_FAIL back to the owning requester. It sits between the client logic and the node's TX_* and PRIORITY pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_WIDTH, `ADDR_WIDTH (8): destination address width
- DATA_WIDTH, `DATA_WIDTH (32): word width
- MAX_RETRY, 2: automatic reissues of a failed single-word message, 0..7
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- REQ_VALID  in  NUM_REQ  per-client word request, level, 4-phase
- REQ_ACK  out  NUM_REQ  per-client word accepted
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  flattened destination addresses; client i at slice i
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  flattened words
- REQ_PEND  in  NUM_REQ  more words follow in this message
- REQ_PRIORITY  in  NUM_REQ  request bus priority
- RESP_SUCC, RESP_FAIL  out  NUM_REQ  per-client message outcome
- RESP_ACK  in  NUM_REQ  client consumed outcome
- TX_ADDR, TX_DATA, TX_PEND, PRIORITY, TX_REQ  out  ADDR_WIDTH/DATA_WIDTH/1/1/1  to node
- TX_ACK, TX_SUCC, TX_FAIL  in  1  from node
- TX_RESP_ACK  out  1  to node

## Operation
- States: IDLE, ISSUE, ACKWAIT, HOLD, RESPWAIT, NODE_RACK, CLIENT_RESP.
- IDLE: the picker selects among asserted REQ_VALID. Clients with REQ_PRIORITY set beat the rest. Within a class, the search starts at rr_ptr. The winner's addr/data/pend/priority are latched into TX_* and PRIORITY; REQ_ACK[w] is set; retry count clears; state goes to ISSUE. rr_ptr becomes w+1 mod NUM_REQ at message end.
- ISSUE: TX_REQ=1 until TX_ACK=1, then TX_REQ=0 and state goes to ACKWAIT.
- ACKWAIT: wait for TX_ACK=0. If the latched pend is 1, go to HOLD. Otherwise go to RESPWAIT.
- HOLD: only the owner's REQ_VALID is accepted. It latches the next word, sets REQ_ACK[owner] and goes to ISSUE. Other clients stay blocked. TX_SUCC or TX_FAIL arriving in HOLD is taken as the message outcome and goes to NODE_RACK.
- RESPWAIT: TX_SUCC or TX_FAIL sets TX_RESP_ACK=1 and records the outcome. State goes to NODE_RACK.
- NODE_RACK: wait for TX_SUCC=TX_FAIL=0, then set TX_RESP_ACK=0.
  - Outcome fail, message single-word, retry_cnt<MAX_RETRY: increment retry_cnt and go to ISSUE with the latched word.
  - Otherwise: go to CLIENT_RESP.
- CLIENT_RESP: RESP_SUCC[o] or RESP_FAIL[o] is held until RESP_ACK[o]=1, then cleared. After RESP_ACK[o]=0, state returns to IDLE.
- Client word handshake: REQ_ACK[i] is held until REQ_VALID[i]=0, independent of the main FSM. The client must not change REQ_* while REQ_ACK[i]=1. In HOLD, a new word is accepted only after the previous REQ_ACK has dropped.
- After RESP_FAIL on a multi-word message, the client abandons the remaining words. A later REQ_VALID from that client is arbitrated as a new message.
- No client is granted while CLIENT_RESP is active for another client.

## Timing
- Reset values: all outputs 0; state IDLE; rr_ptr 0; retry_cnt 0.
- Reset mid-message drops the message silently. No RESP_* is generated.
- All outputs are registered.
- REQ_VALID sampled high in IDLE gives REQ_ACK and TX_* one cycle later, and TX_REQ=1 the cycle after that.
- TX_REQ falls the cycle after TX_ACK is sampled high.
- TX_RESP_ACK rises 1 cycle after TX_SUCC/TX_FAIL is sampled, and falls 1 cycle after both are sampled low.
- Simultaneous TX_SUCC and TX_FAIL: treat as fail.
- Simultaneous requests, equal class: lowest index at or above rr_ptr wins, wrapping.
- retry_cnt is 3 bits and saturates at MAX_RETRY.

## Structure
- State encodings and the MAX_RETRY limit go in include/ulpb_def.v alongside `ADDR_WIDTH/`DATA_WIDTH.
- Sub-module ulpb_rr_pick: combinational priority-masked round-robin picker. Inputs: request vector, priority vector, rr_ptr. Outputs: one-hot grant and index.
- Main FSM, latches and per-client ack logic live in ulpb_tx_arbiter.

## Test plan
- Client 1 sends addr 8'hef, data 32'hdeadbeef, pend 0 → TX_ADDR=8'hef, TX_DATA=32'hdeadbeef; node TX_SUCC → RESP_SUCC[1] only; rr_ptr=2.
- Clients 0, 2, 3 all request, no priority, rr_ptr=2 → grant order 2, 3, 0.
- Client 3 with REQ_PRIORITY=1 and client 0 without, both valid at the same time → client 3 granted first; PRIORITY=1 during its message.
- Client 0 sends a 3-word message (pend 1,1,0); client 1 is valid throughout → three consecutive TX_REQ all from client 0; client 1 is granted only after RESP_SUCC[0] completes.
- Single-word message; node returns TX_FAIL three times, MAX_RETRY=2 → three TX_REQ issues, then RESP_FAIL[owner].
- resetn pulsed low during ISSUE → TX_REQ=0 and all outputs 0 immediately; no RESP_* is asserted afterwards.
